// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: stall generation, D/E forwarding selects, mult/div busy tracking.
// stall and fwd_* are zero-cycle; md_busy and stall_cnt change on the clock edge; stall is the backpressure output.
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       rs_tuse,
   input  logic [1:0]       rt_tuse,
   input  logic [1:0]       tnewE,
   input  logic [1:0]       tnewM,
   input  logic [1:0]       tnewW,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic [4:0]       rsE,
   input  logic [4:0]       rtE,
   input  logic [4:0]       waE,
   input  logic [4:0]       waM,
   input  logic [4:0]       waW,
   input  logic             md_startE,
   input  logic             md_divE,
   input  logic             md_useD,
   output logic             stall,
   output logic [1:0]       fwd_rsD,
   output logic [1:0]       fwd_rtD,
   output logic [1:0]       fwd_rsE,
   output logic [1:0]       fwd_rtE,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

   logic [3:0] mdCnt;
   logic       stallRs;
   logic       stallRt;
   logic       stallMd;

   // A producer blocks the consumer only when its result is ready later than the consumer needs it.
   function automatic logic dataHazard(
      input logic [4:0] srcReg,
      input logic [1:0] tuse,
      input logic [4:0] wE, input logic [1:0] tE,
      input logic [4:0] wM, input logic [1:0] tM,
      input logic [4:0] wW, input logic [1:0] tW
   );
      logic hit;
      hit = ((wE == srcReg) && (tuse < tE)) ||
            ((wM == srcReg) && (tuse < tM)) ||
            ((wW == srcReg) && (tuse < tW));
      return (srcReg != 5'd0) && hit;
   endfunction

   function automatic logic [1:0] fwdSelD(
      input logic [4:0] srcReg,
      input logic [4:0] wE, input logic [1:0] tE,
      input logic [4:0] wM, input logic [1:0] tM
   );
      logic [1:0] sel;
      sel = 2'd0;
      if (srcReg != 5'd0) begin
         if ((wE == srcReg) && (tE == 2'd0))
            sel = 2'd2;
         else if ((wM == srcReg) && (tM == 2'd0))
            sel = 2'd1;
      end
      return sel;
   endfunction

   // W-stage results are always final, so no Tnew qualification on the W path.
   function automatic logic [1:0] fwdSelE(
      input logic [4:0] srcReg,
      input logic [4:0] wM, input logic [1:0] tM,
      input logic [4:0] wW
   );
      logic [1:0] sel;
      sel = 2'd0;
      if (srcReg != 5'd0) begin
         if ((wM == srcReg) && (tM == 2'd0))
            sel = 2'd2;
         else if (wW == srcReg)
            sel = 2'd1;
      end
      return sel;
   endfunction

   always_comb begin
      stallRs = dataHazard(rsD, rs_tuse, waE, tnewE, waM, tnewM, waW, tnewW);
      stallRt = dataHazard(rtD, rt_tuse, waE, tnewE, waM, tnewM, waW, tnewW);
      stallMd = md_useD && (md_busy || md_startE);
      stall   = stallRs || stallRt || stallMd;
   end

   always_comb begin
      fwd_rsD = fwdSelD(rsD, waE, tnewE, waM, tnewM);
      fwd_rtD = fwdSelD(rtD, waE, tnewE, waM, tnewM);
      fwd_rsE = fwdSelE(rsE, waM, tnewM, waW);
      fwd_rtE = fwdSelE(rtE, waM, tnewM, waW);
   end

   // A start while busy cannot come from a well-formed pipeline; it is ignored.
   always_ff @(posedge clk) begin
      if (reset)
         mdCnt <= 4'd0;
      else if (md_startE && (mdCnt == 4'd0))
         mdCnt <= md_divE ? DIV_LOAD : MULT_LOAD;
      else if (mdCnt != 4'd0)
         mdCnt <= mdCnt - 4'd1;
   end

   assign md_busy = (mdCnt != 4'd0);

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; stall_cnt narrowed to 4 bits so saturation is reachable.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [1:0]       rs_tuse, rt_tuse, tnewE, tnewM, tnewW;
   logic [4:0]       rsD, rtD, rsE, rtE, waE, waM, waW;
   logic             md_startE, md_divE, md_useD;
   logic             stall, md_busy;
   logic [1:0]       fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
   logic [CNT_W-1:0] stall_cnt;

   int nCmp = 0;
   int nErr = 0;

   hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
      .tnewE(tnewE), .tnewM(tnewM), .tnewW(tnewW),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .waE(waE), .waM(waM), .waW(waW),
      .md_startE(md_startE), .md_divE(md_divE), .md_useD(md_useD),
      .stall(stall), .fwd_rsD(fwd_rsD), .fwd_rtD(fwd_rtD),
      .fwd_rsE(fwd_rsE), .fwd_rtE(fwd_rtE),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rs_tuse = 2'd3; rt_tuse = 2'd3;
      tnewE = 2'd0; tnewM = 2'd0; tnewW = 2'd0;
      rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
      waE = 5'd0; waM = 5'd0; waW = 5'd0;
      md_startE = 1'b0; md_divE = 1'b0; md_useD = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_busy", md_busy, 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_fwd_rsD", fwd_rsD, 0);
      chk("rst_fwd_rsE", fwd_rsE, 0);
      reset = 1'b0;

      // lw in E feeding add in D
      @(negedge clk); idle(); waE = 5'd1; tnewE = 2'd2; rsD = 5'd1; rs_tuse = 2'd1;
      #1; chk("lw_E_stall", stall, 1); chk("lw_E_fwd", fwd_rsD, 0);
      @(negedge clk); idle(); waM = 5'd1; tnewM = 2'd1; rsD = 5'd1; rs_tuse = 2'd1;
      #1; chk("lw_M_stall", stall, 0); chk("lw_cnt", stall_cnt, 1);
      @(negedge clk); idle(); waM = 5'd1; tnewM = 2'd0; rsE = 5'd1;
      #1; chk("lw_fwd_rsE", fwd_rsE, 2); chk("lw_fwd_rtE", fwd_rtE, 0);

      // beq after ori
      @(negedge clk); idle(); waE = 5'd3; tnewE = 2'd1; rsD = 5'd3; rtD = 5'd3;
      rs_tuse = 2'd0; rt_tuse = 2'd0;
      #1; chk("beq_stall", stall, 1); chk("beq_fwd_E", fwd_rsD, 0);
      @(negedge clk); idle(); waM = 5'd3; tnewM = 2'd0; rsD = 5'd3; rtD = 5'd3;
      rs_tuse = 2'd0; rt_tuse = 2'd0;
      #1; chk("beq_nostall", stall, 0); chk("beq_fwd_rsD", fwd_rsD, 1);
      chk("beq_fwd_rtD", fwd_rtD, 1); chk("beq_cnt", stall_cnt, 2);

      // jal/jr: E wins over M
      @(negedge clk); idle(); waE = 5'd31; tnewE = 2'd0; waM = 5'd31; tnewM = 2'd0;
      rsD = 5'd31; rs_tuse = 2'd0;
      #1; chk("jr_fwd", fwd_rsD, 2); chk("jr_stall", stall, 0);
      @(negedge clk); idle(); waE = 5'd31; tnewE = 2'd0; rsD = 5'd0; rs_tuse = 2'd0;
      #1; chk("r0_fwd", fwd_rsD, 0); chk("r0_fwd_stall", stall, 0);
      @(negedge clk); idle(); waE = 5'd0; tnewE = 2'd2; rsD = 5'd0; rs_tuse = 2'd0;
      #1; chk("r0_nostall", stall, 0);
      @(negedge clk); idle(); waE = 5'd7; tnewE = 2'd3; rtD = 5'd7; rt_tuse = 2'd3;
      #1; chk("tuse3_nostall", stall, 0);
      @(negedge clk); idle(); waW = 5'd4; tnewW = 2'd1; rtD = 5'd4; rt_tuse = 2'd0;
      #1; chk("w_rt_stall", stall, 1);

      // E-stage forwarding priority
      @(negedge clk); idle(); waW = 5'd5; waM = 5'd5; tnewM = 2'd0; rsE = 5'd5; rtE = 5'd5;
      #1; chk("e_fwd_rs_M", fwd_rsE, 2); chk("e_fwd_rt_M", fwd_rtE, 2);
      @(negedge clk); idle(); waW = 5'd5; rsE = 5'd5; rtE = 5'd5;
      #1; chk("e_fwd_rs_W", fwd_rsE, 1); chk("e_fwd_rt_W", fwd_rtE, 1);
      @(negedge clk); idle(); waW = 5'd5; waM = 5'd5; tnewM = 2'd1; rsE = 5'd5;
      #1; chk("e_fwd_M_notready", fwd_rsE, 1);
      @(negedge clk); idle(); waW = 5'd0; rsE = 5'd0;
      #1; chk("e_fwd_r0", fwd_rsE, 0); chk("cnt_3", stall_cnt, 3);

      // stall_cnt saturation
      @(negedge clk); idle(); waW = 5'd4; tnewW = 2'd1; rtD = 5'd4; rt_tuse = 2'd0;
      repeat (11) @(negedge clk);
      #1; chk("cnt_14", stall_cnt, 14);
      repeat (3) @(negedge clk);
      #1; chk("cnt_sat", stall_cnt, 15);

      @(negedge clk); idle(); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1; chk("cnt_cleared", stall_cnt, 0);

      // div with mflo waiting in D
      @(negedge clk); idle(); md_startE = 1'b1; md_divE = 1'b1; md_useD = 1'b1;
      #1; chk("div_start_stall", stall, 1); chk("div_start_busy", md_busy, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); idle(); md_useD = 1'b1;
         #1; chk("div_busy", md_busy, 1); chk("div_stall", stall, 1);
      end
      @(negedge clk); idle(); md_useD = 1'b1;
      #1; chk("div_done_busy", md_busy, 0); chk("div_done_stall", stall, 0);
      chk("div_cnt", stall_cnt, 11);

      // mult, with a stray start during busy that must be ignored
      @(negedge clk); idle(); md_startE = 1'b1;
      #1; chk("mult_start_busy", md_busy, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); idle();
         if (i == 1) begin md_startE = 1'b1; md_divE = 1'b1; end
         #1; chk("mult_busy", md_busy, 1);
      end
      @(negedge clk); idle();
      #1; chk("mult_done", md_busy, 0); chk("mult_cnt", stall_cnt, 11);

      // reset mid-mult
      @(negedge clk); idle(); md_startE = 1'b1;
      @(negedge clk); idle();
      #1; chk("rmult_busy1", md_busy, 1);
      @(negedge clk); idle(); reset = 1'b1;
      #1; chk("rmult_busy2", md_busy, 1);
      @(negedge clk); reset = 1'b0; idle(); md_useD = 1'b1;
      #1; chk("rmult_busy0", md_busy, 0); chk("rmult_stall", stall, 0);
      chk("rmult_cnt", stall_cnt, 0);
      @(negedge clk); idle(); md_useD = 1'b1;
      #1; chk("rmult_stays_idle", md_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
